updown_sweep_ctrl: RTL
======================

# updown_sweep_ctrl

Sequencer for the 4-bit up/down counter datapath: it generates a programmable triangle sweep. The count runs from `lo` up to `hi` and back down to `lo`, repeated `sweeps` times, and the block drives the counter value and the direction `mode` itself. It sits between a command source (start/abort/pause handshake) and any logic that consumes the counter value, and reports `busy`, `done` and parameter errors.

## Interface
- `WIDTH`, 4: counter value width.
- `SWEEP_W`, 4: width of sweep-repeat count.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: launch request. Sampled only in IDLE.
- `abort`  in  1: terminate the current operation.
- `pause`  in  1: freeze the sweep (see Configuration).
- `lo`  in  WIDTH: lower bound. Latched on accepted start.
- `hi`  in  WIDTH: upper bound. Latched on accepted start.
- `sweeps`  in  SWEEP_W: number of full up/down sweeps. Latched on accepted start.
- `y`  out  WIDTH: current counter value.
- `mode`  out  1: direction. 1 = counting up, 0 = down or idle.
- `busy`  out  1: high in UP and DOWN.
- `done`  out  1: one-cycle pulse on normal completion.
- `err`  out  1: one-cycle pulse on a rejected start.
- `sweep_cnt`  out  SWEEP_W: sweeps completed in the current run.

## Operation
- States: IDLE, UP, DOWN, DONE. All outputs are registered.
- Reset (`rst_n` low, asynchronous, any state): state = IDLE, `y` = 0, `mode` = 0, `busy` = 0, `done` = 0, `err` = 0, `sweep_cnt` = 0, latched `lo`/`hi`/`sweeps` = 0.
- IDLE with `start` = 1:
  - If `lo` >= `hi` or `sweeps` = 0: `err` = 1 for one cycle, stay in IDLE, `y` unchanged.
  - Otherwise: latch the parameters, `y` <= `lo`, `sweep_cnt` <= 0, go to UP.
- UP: `y` <= `y` + 1. When `y` + 1 = `hi`, go to DOWN.
- DOWN: `y` <= `y` − 1. When `y` − 1 = latched `lo`, `sweep_cnt` <= `sweep_cnt` + 1.
  - If `sweep_cnt` + 1 = latched `sweeps`, go to DONE.
  - Otherwise go to UP.
- DONE: `done` = 1 for exactly one cycle, `y` holds `lo`, then IDLE. `sweep_cnt` holds its final value until the next accepted start.
- `abort` in UP, DOWN or DONE: go to IDLE on the next edge. `y` and `sweep_cnt` hold their current values, `done` is not pulsed, `mode` = 0.
- Priority: reset > `abort` > `pause` > normal stepping.
- `start` outside IDLE is ignored. Input changes to `lo`/`hi`/`sweeps` during a run have no effect.
- Arithmetic is WIDTH-bit unsigned. Because `lo` < `hi` is enforced, `y` never wraps. `lo` = 0 with `hi` = 2^WIDTH − 1 is legal and must not wrap.

## Timing
- Accepted start at edge E: `y` = `lo`, `busy` = 1 and `mode` = 1 are visible after E.
- Each unpaused cycle moves `y` by exactly 1. One sweep takes 2·(`hi` − `lo`) cycles.
- `done` rises 1 + 2·(`hi` − `lo`)·`sweeps` cycles after E, counting paused cycles as extra. `busy` falls in the same cycle `done` rises.
- `mode` = 1 exactly in UP cycles. It is 0 in the cycle `y` = `hi` is first presented in DOWN.
- `err` is visible in the cycle after the rejected start. A new start is accepted in the cycle after DONE or abort.

## Configuration
- `UDSWEEP_PAUSE_EN` defined:
  - `pause` = 1 in UP or DOWN holds state, `y`, `mode` and `sweep_cnt` unchanged. `busy` stays 1.
  - `pause` has no effect in IDLE and DONE.
- `UDSWEEP_PAUSE_EN` undefined: the `pause` port exists but is ignored, and the sweep always steps every cycle.

## Test plan
- Basic sweep: `lo` = 2, `hi` = 5, `sweeps` = 1.
  - Response: `y` = 2,3,4,5,4,3,2 on successive cycles, and `mode` = 1,1,1,0,0,0.
  - `done` pulses 7 cycles after the start edge, then `busy` = 0 and `sweep_cnt` = 1.
- Multi-sweep: `lo` = 0, `hi` = 15, `sweeps` = 3.
  - Response: `y` never wraps, and `sweep_cnt` steps 1, 2, 3.
  - `done` pulses at cycle 1 + 90 after the start edge.
- Parameter error: `lo` = 7, `hi` = 7 with `sweeps` = 2, then `lo` = 1, `hi` = 4 with `sweeps` = 0.
  - Response: `err` pulses once per start, `busy` stays 0 and `y` is unchanged.
- Pause (macro defined): `lo` = 2, `hi` = 5, `sweeps` = 1, with `pause` high for 4 cycles while `y` = 4 in UP.
  - Response: `y` holds 4 for those cycles, and `done` arrives 4 cycles later than in the basic sweep.
  - With the macro undefined, timing is identical to the basic sweep.
- Abort and restart: abort at `y` = 3 in DOWN.
  - Response: IDLE next cycle with `y` = 3, no `done`, and `start` ignored while `busy`.
  - A new start is accepted the cycle after abort.
- Reset mid-sweep: `rst_n` low asynchronously at `y` = 4.
  - Response: all outputs 0 immediately, without waiting for a clock edge.
  - After release, the block stays in IDLE until `start`.

Source files
------------

// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: triangle sweep sequencer, y runs lo->hi->lo repeated `sweeps` times.
// Define UDSWEEP_PAUSE_EN to let `pause` freeze the sweep in UP/DOWN.
module updown_sweep_ctrl #(
    parameter int WIDTH   = 4,
    parameter int SWEEP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               pause,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [SWEEP_W-1:0] sweeps,
    output logic [WIDTH-1:0]   y,
    output logic               mode,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [SWEEP_W-1:0] sweep_cnt
);
    typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;
    state_t             r_state;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [SWEEP_W-1:0] r_sweeps;
    logic [WIDTH-1:0]   w_y_inc;
    logic [WIDTH-1:0]   w_y_dec;
    logic [SWEEP_W-1:0] w_cnt_inc;
    logic               w_bad;
    logic               w_hold;
    assign w_y_inc   = y + WIDTH'(1);
    assign w_y_dec   = y - WIDTH'(1);
    assign w_cnt_inc = sweep_cnt + SWEEP_W'(1);
    assign w_bad     = (lo >= hi) || (sweeps == '0);
`ifdef UDSWEEP_PAUSE_EN
    assign w_hold = pause && (r_state == UP || r_state == DOWN);
`else
    logic w_unused_pause;
    assign w_unused_pause = pause;
    assign w_hold         = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_lo      <= '0;
            r_hi      <= '0;
            r_sweeps  <= '0;
            y         <= '0;
            mode      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            sweep_cnt <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort && r_state != IDLE) begin
                r_state <= IDLE;
                mode    <= 1'b0;
                busy    <= 1'b0;
            end else if (!w_hold) begin
                case (r_state)
                    IDLE: begin
                        if (start && w_bad) begin
                            err <= 1'b1;
                        end else if (start) begin
                            r_lo      <= lo;
                            r_hi      <= hi;
                            r_sweeps  <= sweeps;
                            y         <= lo;
                            sweep_cnt <= '0;
                            r_state   <= UP;
                            mode      <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    UP: begin
                        y <= w_y_inc;
                        if (w_y_inc == r_hi) begin
                            r_state <= DOWN;
                            mode    <= 1'b0;
                        end
                    end
                    DOWN: begin
                        y <= w_y_dec;
                        if (w_y_dec == r_lo) begin
                            sweep_cnt <= w_cnt_inc;
                            // last sweep lands on lo together with done; busy drops in the same cycle
                            if (w_cnt_inc == r_sweeps) begin
                                r_state <= DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                r_state <= UP;
                                mode    <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule
